// File: rtl/rp_8bit_uart_if.sv
// rp_8bit I/O peripheral bus: the core drives the request side (master),
// a peripheral answers with registered read data (slave).
interface rp_8bit_uart_if;
  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;

  modport master (output io_wen, io_ren, io_adr, io_wdt, io_msk, input io_rdt);
  modport slave  (input io_wen, io_ren, io_adr, io_wdt, io_msk, output io_rdt);
endinterface

// File: rtl/rp_8bit_uart.sv
// rp_8bit I/O-bus UART: fixed 8N1, TFD-deep TX FIFO, single-byte RX buffer,
// 16x oversampling baud generator and level interrupt requests.
module rp_8bit_uart #(
  parameter logic [5:0]  BASE = 6'h0c,
  parameter int unsigned TFD  = 4
) (
  input  logic          clk,
  input  logic          rst,
  rp_8bit_uart_if.slave bus,
  output logic [1:0]    irq_req,
  input  logic          uart_rxd,
  output logic          uart_txd
);

  localparam int unsigned AW       = $clog2(TFD);
  localparam logic [5:0]  ADR_UDR  = BASE;
  localparam logic [5:0]  ADR_USR  = BASE + 6'd1;
  localparam logic [5:0]  ADR_UCR  = BASE + 6'd2;
  localparam logic [5:0]  ADR_UBRR = BASE + 6'd3;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]  io_rdt_q, io_rdt_d;
  logic [3:0]  ucr_q, ucr_d;
  logic [7:0]  ubrr_q, ubrr_d;
  logic [7:0]  presc_q, presc_d;
  logic        rxc_q, rxc_d, fe_q, fe_d, dor_q, dor_d, tov_q, tov_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  fifo_mem_q [TFD];
  state_e      tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  state_e      rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;

  logic       sel_udr, sel_usr, sel_ucr, sel_ubrr;
  logic       udr_wr, udr_rd, usr_wr, ucr_wr, ubrr_wr;
  logic       tick, fifo_empty, fifo_full, tx_pop, push_ok, rx_fall, rx_done;
  logic [7:0] wmask, usr_val;

  assign sel_udr  = bus.io_adr == ADR_UDR;
  assign sel_usr  = bus.io_adr == ADR_USR;
  assign sel_ucr  = bus.io_adr == ADR_UCR;
  assign sel_ubrr = bus.io_adr == ADR_UBRR;
  assign udr_wr   = bus.io_wen && sel_udr;
  assign udr_rd   = bus.io_ren && sel_udr;
  assign usr_wr   = bus.io_wen && sel_usr;
  assign ucr_wr   = bus.io_wen && sel_ucr;
  assign ubrr_wr  = bus.io_wen && sel_ubrr;
  assign wmask    = bus.io_wdt & bus.io_msk;

  assign tick       = presc_q == ubrr_q;
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tx_pop     = (tx_state_q == S_IDLE) && ucr_q[1] && !fifo_empty && tick;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign push_ok    = udr_wr && (!fifo_full || tx_pop);
  assign rx_fall    = rxd_prev_q && !rxd_sync_q;
  assign usr_val    = {2'b00, tov_q, dor_q, fe_q, !fifo_full,
                       fifo_empty && (tx_state_q == S_IDLE), rxc_q};

  always_comb begin
    // NOTE: every _d starts at its hold value so no branch can leave a latch behind.
    io_rdt_d   = io_rdt_q;
    ucr_d      = ucr_q;
    ubrr_d     = ubrr_q;
    presc_d    = presc_q + 8'd1;
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = tx_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rbuf_d     = rbuf_q;
    rxc_d      = rxc_q && !udr_rd;
    fe_d       = fe_q  && !(usr_wr && wmask[3]);
    dor_d      = dor_q && !(usr_wr && wmask[4]);
    tov_d      = tov_q && !(usr_wr && wmask[5]);

    if (bus.io_ren) begin
      if (sel_udr)       io_rdt_d = rbuf_q;
      else if (sel_usr)  io_rdt_d = usr_val;
      else if (sel_ucr)  io_rdt_d = {4'b0000, ucr_q};
      else if (sel_ubrr) io_rdt_d = ubrr_q;
    end
    if (ucr_wr)  ucr_d  = wmask[3:0] | (ucr_q & ~bus.io_msk[3:0]);
    if (ubrr_wr) ubrr_d = wmask | (ubrr_q & ~bus.io_msk);
    if (ubrr_wr || tick) presc_d = '0;

    unique case (tx_state_q)
      S_IDLE: if (tx_pop) begin
        tx_state_d = S_START;
        tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
        tx_tick_d  = '0;
        txd_d      = 1'b0;
      end
      S_START: if (tick) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      S_DATA: if (tick) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            txd_d = tx_shift_q[1];
          end
        end
      end
      S_STOP: if (tick) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) tx_state_d = S_IDLE;
      end
    endcase

    if (!ucr_q[0]) begin
      rx_state_d = S_IDLE;
    end else begin
      unique case (rx_state_q)
        S_IDLE: if (rx_fall) begin
          rx_state_d = S_START;
          rx_tick_d  = '0;
        end
        S_START: if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7 && rxd_sync_q) begin
            rx_state_d = S_IDLE;
          end else if (rx_tick_q == 4'd15) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end
        end
        S_DATA: if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_tick_q == 4'd15) begin
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          end
        end
        S_STOP: if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
          end
        end
      endcase
    end

    // Sticky sets win over a same-cycle software clear.
    if (rx_done) begin
      if (!rxd_sync_q) begin
        fe_d = 1'b1;
      end else if (!rxc_q || udr_rd) begin
        rbuf_d = rx_shift_q;
        rxc_d  = 1'b1;
      end else begin
        dor_d = 1'b1;
      end
    end
    if (udr_wr && fifo_full && !tx_pop) tov_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      io_rdt_q   <= '0;
      ucr_q      <= '0;
      ubrr_q     <= '0;
      presc_q    <= '0;
      rxc_q      <= 1'b0;
      fe_q       <= 1'b0;
      dor_q      <= 1'b0;
      tov_q      <= 1'b0;
      rbuf_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      io_rdt_q   <= io_rdt_d;
      ucr_q      <= ucr_d;
      ubrr_q     <= ubrr_d;
      presc_q    <= presc_d;
      rxc_q      <= rxc_d;
      fe_q       <= fe_d;
      dor_q      <= dor_d;
      tov_q      <= tov_d;
      rbuf_q     <= rbuf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.io_wdt;
  end

  assign bus.io_rdt = io_rdt_q;
  assign uart_txd   = txd_q;
  assign irq_req    = {!fifo_full && ucr_q[3], rxc_q && ucr_q[2]};

endmodule
